excess3_serial_decoder: RTL
===========================

# excess3_serial_decoder

Bit-serial Excess-3 to BCD decoder: the receive-side counterpart of our BCD-to-Excess-3 encoder. It accepts a framed, LSB-first serial stream of Excess-3 digits and subtracts 3 per digit with a borrow state machine. It emits each decoded BCD bit serially, and assembles a packed multi-digit BCD word with a validity check on every digit. It sits between the serial link receiver and the BCD display/arithmetic datapath.

## Interface
- DIGITS, 4, number of Excess-3 digits per frame (1..8); dat_out width is 4*DIGITS.
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- bit_in  in  1  serial Excess-3 data, LSB of each digit first, digit 0 first.
- bit_vld  in  1  qualifies bit_in; a bit is accepted only on cycles with bit_vld=1.
- frame  in  1  start-of-word marker; meaningful only when bit_vld=1; marks bit 0 of digit 0.
- bit_out  out  1  decoded BCD bit, registered.
- bit_out_vld  out  1  one-cycle pulse qualifying bit_out.
- dat_out  out  4*DIGITS  packed BCD word; digit k in bits [4k+3:4k]; held between words.
- dat_vld  out  1  one-cycle pulse: dat_out/err updated.
- err  out  1  word contained at least one invalid code; valid with dat_vld, held until next dat_vld.

## Operation
- Modes: IDLE and RUN. Reset enters IDLE. Accepted bits in IDLE without frame are dropped, with no output.
- Accepted bit with frame=1 (any mode): bit counter=0, digit counter=0, borrow=0, discard partial word, process the bit as bit 0 of digit 0, enter RUN.
- Per-digit subtrahend is 0011 (LSB first: 1,1,0,0). Serial subtraction on input bit x, borrow b:
  - bit0: d=~x, b'=~x.
  - bit1: d=~(x^b), b'=~x|b.
  - bit2: d=x^b, b'=~x&b.
  - bit3: d=x^b; final borrow=~x&b.
- The FSM tracks bit position and borrow through the states B0, B1_0, B1_1, B2_0, B2_1, B3_0, B3_1, where the suffix is the incoming borrow.
- The 4 input bits shift into a nibble register. At bit3 the digit is invalid if the final borrow is 1 (code < 0011) or the nibble is > 1100.
- Valid digit: the 4 d bits are written into field [digit] of the assembly register. Invalid digit: the field is forced to 0000 and the word error flag is set.
- bit_out follows the serial arithmetic even for invalid digits. Only the assembled field is zeroed.
- After bit3 of digit DIGITS-1: the assembly register is copied to dat_out, the error flag to err, dat_vld pulses, and the block returns to IDLE. The next word requires frame.
- bit_vld=0 holds all state; gaps of any length are allowed between bits.
- frame mid-word aborts the partial word: no dat_vld, dat_out/err unchanged, and the new word starts.

## Timing
- Reset values: bit_out=0, bit_out_vld=0, dat_out=0, dat_vld=0, err=0, mode IDLE, counters 0, borrow 0.
- Reset dominates every other input in the same cycle.
- bit_out/bit_out_vld: 1 cycle after the accepted bit (registered).
- dat_vld: asserted the cycle after the final bit is accepted, for exactly 1 cycle. It coincides with bit_out_vld for that last bit.
- Back-to-back: a frame bit in the cycle after the final bit is accepted normally. The old word's dat_vld still fires, and the new word is unaffected.
- Throughput: one bit per cycle; one word per 4*DIGITS accepted bits.

## Test plan
- Reset: drive rst=1 for 2 cycles with random bit_in/bit_vld/frame -> all outputs 0. Then bits without frame -> no bit_out_vld, no dat_vld.
- Nominal, DIGITS=4: frame, then digits 0100,1100,0011,1000 LSB first, contiguous -> bit_out stream 1,0,0,0 / 1,0,0,1 / 0,0,0,0 / 1,0,1,0. dat_out=16'h5091, err=0, dat_vld once, 1 cycle after the 16th bit.
- Invalid codes: digit1=0010 and digit3=1101, others 0100 -> dat_out=16'h0101, err=1. The next valid word clears err.
- Gaps: the nominal word with bit_vld toggled randomly (1-5 idle cycles) -> identical dat_out, and exactly 16 bit_out_vld pulses.
- Mid-word frame: 6 bits of a word, then a frame and a full word 0011,0011,0011,0011 -> single dat_vld, dat_out=16'h0000, err=0.
- Reset mid-word: rst after 9 bits, then a full nominal word -> dat_out=16'h5091, with no stale digits and no dat_vld before the completion.

Source files
------------

// File: rtl/excess3_serial_decoder.sv
// Bit-serial Excess-3 to BCD decoder: LSB-first digits, subtract-3 borrow FSM,
// registered serial BCD output and a packed multi-digit word with per-digit validity.
module excess3_serial_decoder #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bit_in,
    input  logic                  bit_vld,
    input  logic                  frame,
    output logic                  bit_out,
    output logic                  bit_out_vld,
    output logic [4*DIGITS-1:0]   dat_out,
    output logic                  dat_vld,
    output logic                  err
);

    // Suffix is the borrow coming into that bit position.
    typedef enum logic [2:0] {IDLE, B0, B1_0, B1_1, B2_0, B2_1, B3_0, B3_1} state_t;

    state_t              state_q, state_d, cur;
    logic [2:0]          dig_q, dig_base, dig_d;
    logic [2:0]          sh_q, dsh_q;
    logic [4*DIGITS-1:0] asm_q, asm_d;
    logic                werr_q, werr_d;
    logic                frame_acc, proc, dbit, fin_borrow, digit_done, last, word_done;
    logic [3:0]          code, dec;
    logic                bad;

    // A framed bit always restarts at bit 0 of digit 0, whatever mode we were in.
    assign frame_acc = bit_vld & frame;
    assign cur       = frame_acc ? B0 : state_q;
    assign dig_base  = frame_acc ? 3'd0 : dig_q;
    assign last      = (dig_base == 3'(DIGITS - 1));

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bit_vld) begin
            case (cur)
                B0:         state_d = bit_in ? B1_0 : B1_1;
                B1_0:       state_d = bit_in ? B2_0 : B2_1;
                B1_1:       state_d = B2_1;
                B2_0:       state_d = B3_0;
                B2_1:       state_d = bit_in ? B3_0 : B3_1;
                B3_0, B3_1: state_d = last ? IDLE : B0;
                default:    state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        proc       = bit_vld && (cur != IDLE);
        digit_done = bit_vld && (cur == B3_0 || cur == B3_1);
        fin_borrow = (cur == B3_1) && !bit_in;
        case (cur)
            B0, B1_0, B2_1, B3_1: dbit = ~bit_in;
            B1_1, B2_0, B3_0:     dbit = bit_in;
            default:              dbit = 1'b0;
        endcase
    end

    // Assembly of the packed word; an invalid digit lands as 0000 and flags the word.
    always_comb begin
        code      = {bit_in, sh_q};
        dec       = {dbit, dsh_q};
        bad       = fin_borrow | (code > 4'd12);
        asm_d     = frame_acc ? '0 : asm_q;
        werr_d    = frame_acc ? 1'b0 : werr_q;
        dig_d     = dig_base;
        word_done = digit_done && last;
        if (digit_done) begin
            for (int k = 0; k < DIGITS; k++)
                if (dig_base == 3'(k)) asm_d[4*k +: 4] = bad ? 4'd0 : dec;
            werr_d = werr_d | bad;
            dig_d  = last ? 3'd0 : dig_base + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_out     <= 1'b0;
            bit_out_vld <= 1'b0;
            dat_out     <= '0;
            dat_vld     <= 1'b0;
            err         <= 1'b0;
            dig_q       <= 3'd0;
            sh_q        <= 3'd0;
            dsh_q       <= 3'd0;
            asm_q       <= '0;
            werr_q      <= 1'b0;
        end else begin
            bit_out_vld <= proc;
            dat_vld     <= word_done;
            if (proc) begin
                bit_out <= dbit;
                sh_q    <= {bit_in, sh_q[2:1]};
                dsh_q   <= {dbit, dsh_q[2:1]};
                asm_q   <= asm_d;
                werr_q  <= werr_d;
                dig_q   <= dig_d;
            end
            if (word_done) begin
                dat_out <= asm_d;
                err     <= werr_d;
            end
        end
    end

endmodule
